// File: rtl/button_event_classifier.sv
`default_nettype none
// ============================================================================
// Module   : button_event_classifier
// Function : Turns a debounced button level into one-cycle gesture pulses
//            (press, release, short, double, long, repeat) and a held level.
// Revision : 1.0
// ============================================================================
module button_event_classifier #(
    parameter int LONG_CYCLES       = 50_000_000,
    parameter int DOUBLE_GAP_CYCLES = 12_500_000,
    parameter int REPEAT_CYCLES     = 5_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic double_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int C_MAX_A = (LONG_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int C_MAX   = (C_MAX_A > REPEAT_CYCLES) ? C_MAX_A : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(C_MAX) + 1;

    localparam logic [CNT_W-1:0] C_LONG_TERM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_GAP_TERM  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);

    localparam logic [2:0] C_IDLE      = 3'd0;
    localparam logic [2:0] C_PRESSED   = 3'd1;
    localparam logic [2:0] C_LONG_HELD = 3'd2;
    localparam logic [2:0] C_WAIT_GAP  = 3'd3;
    localparam logic [2:0] C_SECOND    = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_q;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_press;
    logic             w_release;
    logic             w_short;
    logic             w_double;
    logic             w_long;
    logic             w_repeat;

    assign w_rise = btn_i & ~r_btn_q;
    assign w_fall = ~btn_i & r_btn_q;

    // A fall is always tested before a count expiry so it wins on a tie.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_short     = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            C_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_press     = 1'b1;
                    w_state_nxt = C_PRESSED;
                end
            end
            C_PRESSED: begin
                if (w_fall) begin
                    w_release   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = C_WAIT_GAP;
                end else if (r_cnt == C_LONG_TERM) begin
                    w_long      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = C_LONG_HELD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            C_LONG_HELD: begin
                if (w_fall) begin
                    w_release   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = C_IDLE;
                end else if (r_cnt == C_REP_TERM) begin
                    w_repeat  = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            C_WAIT_GAP: begin
                if (r_cnt == C_GAP_TERM) begin
                    // Gap expired: a rise on this exact cycle starts a fresh press.
                    w_short     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_press     = w_rise;
                    w_state_nxt = w_rise ? C_PRESSED : C_IDLE;
                end else if (w_rise) begin
                    w_press     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = C_SECOND;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            C_SECOND: begin
                if (w_fall) begin
                    w_release   = 1'b1;
                    w_double    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = C_IDLE;
                end else if (r_cnt == C_LONG_TERM) begin
                    w_long      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = C_LONG_HELD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= C_IDLE;
            r_cnt     <= '0;
            r_btn_q   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            double_o  <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;
            held_o    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_btn_q   <= btn_i;
            press_o   <= w_press;
            release_o <= w_release;
            short_o   <= w_short;
            double_o  <= w_double;
            long_o    <= w_long;
            repeat_o  <= w_repeat;
            held_o    <= (w_state_nxt == C_PRESSED) || (w_state_nxt == C_LONG_HELD) ||
                         (w_state_nxt == C_SECOND);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_event_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_classifier
// Function : Randomized and directed bench for button_event_classifier using a
//            timestamp-based reference model of the gesture rules.
// Revision : 1.0
// ============================================================================
module tb_button_event_classifier;

    localparam int LONG_CYCLES       = 20;
    localparam int DOUBLE_GAP_CYCLES = 10;
    localparam int REPEAT_CYCLES     = 5;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic press, rel, shrt, dbl, lng, rpt, held;

    int checks = 0;
    int errors = 0;

    // Reference model: gestures judged from the cycle stamps of the last edges.
    int   t;
    int   press_t, release_t, long_t;
    bit   m_held, m_longed, m_second, m_gap, btn_prev;
    logic [6:0] exp_out;

    button_event_classifier #(
        .LONG_CYCLES      (LONG_CYCLES),
        .DOUBLE_GAP_CYCLES(DOUBLE_GAP_CYCLES),
        .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_dut (
        .clock    (clk),
        .reset    (rst),
        .btn_i    (btn),
        .press_o  (press),
        .release_o(rel),
        .short_o  (shrt),
        .double_o (dbl),
        .long_o   (lng),
        .repeat_o (rpt),
        .held_o   (held)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {press, rel, shrt, dbl, lng, rpt, held};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t got=%b expected=%b (press,release,short,double,long,repeat,held)",
                     tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        t        = 0;
        m_held   = 0;
        m_longed = 0;
        m_second = 0;
        m_gap    = 0;
        btn_prev = 0;
        exp_out  = '0;
    endtask

    task automatic model_step(input bit b);
        bit rise, fall;
        bit p, r, s, d, l, rp;
        int k;
        rise = b & ~btn_prev;
        fall = ~b & btn_prev;
        {p, r, s, d, l, rp} = '0;
        k = t - release_t;
        if (m_gap && rise) begin
            p        = 1;
            m_gap    = 0;
            m_held   = 1;
            m_longed = 0;
            press_t  = t;
            if (k >= DOUBLE_GAP_CYCLES) begin
                s        = 1;
                m_second = 0;
            end else begin
                m_second = 1;
            end
        end else if (m_gap && k >= DOUBLE_GAP_CYCLES) begin
            s     = 1;
            m_gap = 0;
        end else if (!m_held && rise) begin
            p        = 1;
            m_held   = 1;
            m_longed = 0;
            m_second = 0;
            press_t  = t;
        end else if (m_held && fall) begin
            r      = 1;
            m_held = 0;
            if (!m_longed) begin
                if (m_second) d = 1;
                else begin
                    m_gap     = 1;
                    release_t = t;
                end
            end
        end else if (m_held && !m_longed && (t - press_t) == LONG_CYCLES) begin
            l        = 1;
            m_longed = 1;
            long_t   = t;
        end else if (m_held && m_longed && t > long_t && ((t - long_t) % REPEAT_CYCLES) == 0) begin
            rp = 1;
        end
        exp_out  = {p, r, s, d, l, rp, m_held};
        btn_prev = b;
        t++;
    endtask

    // Called at a falling edge: drive one cycle of btn and check the result.
    task automatic drive(input bit b, input string tag);
        btn = b;
        model_step(b);
        @(negedge clk);
        check(tag, outs(), exp_out);
    endtask

    task automatic run(input bit b, input int n, input string tag);
        for (int i = 0; i < n; i++) drive(b, tag);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        check("reset_async", outs(), 7'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("reset_hold", outs(), 7'd0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int hi, lo, sel;
        rst = 1'b1;
        btn = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_init", outs(), 7'd0);
        do_reset(3);
        run(0, 3, "idle");

        run(1, 5, "short_hold");
        run(0, 14, "short_gap");

        run(1, 5, "dbl_first");
        run(0, 4, "dbl_gap");
        run(1, 5, "dbl_second");
        run(0, 14, "dbl_after");

        run(1, 32, "long_hold");
        run(0, 14, "long_after");

        run(1, 5, "edge_first");
        run(0, DOUBLE_GAP_CYCLES, "edge_gap");
        run(1, 6, "edge_fresh");
        run(0, 4, "edge_gap2");
        run(1, 3, "edge_second");
        run(0, 14, "edge_after");

        run(1, 10, "rst_hold");
        do_reset(2);
        run(1, 8, "rst_repress");
        run(0, 14, "rst_after");

        // Random segments biased toward every terminal-count boundary.
        for (int seg = 0; seg < 60; seg++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       hi = $urandom_range(1, 8);
                1:       hi = LONG_CYCLES + $urandom_range(0, 1) - 1;
                2:       hi = LONG_CYCLES + REPEAT_CYCLES * $urandom_range(0, 2) + $urandom_range(0, 1);
                default: hi = $urandom_range(1, 40);
            endcase
            sel = $urandom_range(0, 2);
            case (sel)
                0:       lo = DOUBLE_GAP_CYCLES + $urandom_range(0, 2) - 1;
                1:       lo = $urandom_range(1, 4);
                default: lo = $urandom_range(1, 16);
            endcase
            run(1, hi, "rand_hi");
            run(0, lo, "rand_lo");
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
        end
        run(0, 16, "flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at t=%0t got=running expected=finished", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
